store_queue_fwd: RTL and testbench
==================================

# store_queue_fwd

Parametrised in-order store queue with store-to-load forwarding, branch-flush recovery and a registered memory drain port. Stores are allocated at decode with their PC. Address and data are filled at execute by queue index. Loads probe the queue for the youngest older matching store. Committed stores leave from the head toward data memory. It sits between the decode/execute stages and the data memory in the pipelined RISC-V core, on a single clock.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥2
- AW, 8, store/load word address width
- DW, 32, data width
- PCW, 32, PC width
- derived IW = log2(DEPTH) index width; PW = IW+1 pointer width (MSB = wrap bit)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- alloc_en  in  1  allocate a store entry at tail (decode)
- alloc_pc  in  PCW  PC of allocated store
- alloc_ptr  out  PW  current tail pointer, i.e. the id given to the store allocated this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  PW  occupied entries
- fill_en  in  1  write address/data to an allocated entry (execute)
- fill_idx  in  IW  entry index (alloc_ptr[IW-1:0])
- fill_addr  in  AW
- fill_data  in  DW
- ld_en  in  1  load probe
- ld_addr  in  AW
- ld_tail  in  PW  tail pointer captured when the load was decoded; stores older than the load are [head, ld_tail)
- ld_hit  out  1  forward ld_data
- ld_stall  out  1  older store with unknown address found first; load must retry
- ld_data  out  DW
- commit_en  in  1  retire the head store
- head_ready  out  1  head entry is valid and filled
- flush_en  in  1  squash younger stores
- flush_tail  in  PW  new tail; entries [flush_tail, tail) are invalidated
- mem_we  out  1  registered memory write strobe
- mem_addr  out  AW
- mem_data  out  DW
- mem_pc  out  PCW  PC of drained store, for trace

## Operation
- Each entry holds: valid, filled, pc, addr, data. Head and tail are PW-bit wrapping pointers.
- count = tail − head, computed modulo 2^PW. full and empty are derived from the registered pointers.
- **Alloc.** If alloc_en && !full: entry[tail] gets valid=1, filled=0, pc=alloc_pc, and tail increments. If full, alloc is ignored; the upstream stage must stall on full.
- **Fill.** If fill_en and entry[fill_idx].valid: write addr and data, and set filled=1. A fill to an invalid entry is ignored.
- **Forwarding (combinational, registered state only, no same-cycle fill bypass).**
  - Scan entries from ld_tail−1 down to head, youngest first.
  - The first valid entry with filled=0 gives ld_stall=1.
  - Otherwise, the first entry with addr==ld_addr gives ld_hit=1 and ld_data=its data.
  - If no entry decides, the result is a miss (both 0, ld_data=0).
  - ld_en=0 forces all three outputs to 0.
- **Commit.** If commit_en && head_ready:
  - next edge: mem_we=1 and mem_addr/mem_data/mem_pc take the head entry's values;
  - the head entry is cleared and head increments.
  - commit_en with !head_ready is a no-op and mem_we=0.
- **Flush.**
  - tail is loaded from flush_tail, and the valid bits in [flush_tail, old tail) are cleared.
  - Flush has priority over alloc in the same cycle; that alloc is dropped.
  - Fills to squashed indices in the same cycle are dropped.
  - Commit proceeds independently.
  - flush_tail outside [head, tail] is illegal; the bench asserts on it.
- **Simultaneous alloc and commit.** Both occur, so count is unchanged. full is evaluated before the pop, so alloc when full is still refused.

## Timing
- Reset: all valid/filled bits, head, tail, count = 0; empty=1; full=0; mem_we=0; mem_addr, mem_data, mem_pc = 0.
- Reset asserted mid-operation discards all entries immediately, including the in-flight mem_we.
- Latency:
  - alloc, fill and flush become visible the cycle after the edge;
  - the forwarding result is in the same cycle;
  - the drain write appears one cycle after commit.
- mem_we is a single-cycle pulse per committed store. Back-to-back commits give consecutive pulses.
- Pointer wrap: the index is ptr[IW-1:0]. Wrap-bit inequality with equal index means full.

## Structure
- Package sq_pkg holds:
  - the entry struct (valid, filled, pc, addr, data);
  - a pointer-distance function used for count and for age checks in the forwarding scan;
  - the default parameter constants.
- One sub-module, sq_fwd_select: a parametrised youngest-first priority scan over DEPTH entries. It returns hit, stall and the selected index.

## Test plan
- **Reset and fill-up.** After reset, 16 allocs (PC 0x100..0x13C) → count=16 and full=1. A 17th alloc is ignored and alloc_ptr stays 0x10.
- **Forward youngest.** Fill idx0 with addr 0x20 / 0xAAAA and idx2 with addr 0x20 / 0xBBBB, then probe ld_addr=0x20, ld_tail=3 → ld_hit=1, ld_data=0xBBBB.
- **Unknown-address stall.** idx1 is unfilled, idx0 is filled with a match, probe ld_tail=2 → ld_stall=1, ld_hit=0. Filling idx1 with addr 0x44 then gives a hit on idx0.
- **Drain.** With head filled (0x10, 0x1234), commit_en → the next cycle shows mem_we=1, mem_addr=0x10, mem_data=0x1234, and count decrements. commit_en on an unfilled head → mem_we=0.
- **Flush with wrap.** Head=14, tail=20 (wrapped); flush_tail=17 → tail=17, entries 1–3 invalid, count=3. A simultaneous alloc is dropped.
- **Async reset.** Assert rstn low mid-commit → mem_we=0 and empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sq_pkg.sv
// Shared types and helpers for the store queue: default sizing, the entry
// layout and the wrapping pointer-distance function used for occupancy and age.
package sq_pkg;

    localparam int SQ_DEPTH = 16;
    localparam int SQ_AW    = 8;
    localparam int SQ_DW    = 32;
    localparam int SQ_PCW   = 32;

    typedef struct packed {
        logic              valid;
        logic              filled;
        logic [SQ_PCW-1:0] pc;
        logic [SQ_AW-1:0]  addr;
        logic [SQ_DW-1:0]  data;
    } sq_entry_t;

    // Distance from from_ptr forward to to_ptr, modulo 2^pw.
    function automatic logic [31:0] ptr_dist(input logic [31:0] from_ptr,
                                             input logic [31:0] to_ptr,
                                             input int unsigned pw);
        logic [31:0] mask;
        mask = (32'd1 << pw) - 32'd1;
        return (to_ptr - from_ptr) & mask;
    endfunction

endpackage

// File: rtl/sq_fwd_select.sv
// Youngest-first priority scan over the entries older than a load.
// The youngest entry that is either unfilled or address-matching decides.
module sq_fwd_select
    import sq_pkg::*;
#(
    parameter  int DEPTH = SQ_DEPTH,
    localparam int IW    = $clog2(DEPTH),
    localparam int PW    = IW + 1
) (
    input  logic [DEPTH-1:0] i_valid,
    input  logic [DEPTH-1:0] i_filled,
    input  logic [DEPTH-1:0] i_match,
    input  logic [PW-1:0]    i_head,
    input  logic [PW-1:0]    i_ld_tail,
    output logic             o_hit,
    output logic             o_stall,
    output logic [IW-1:0]    o_sel
);

    logic [PW-1:0] w_older;

    assign w_older = PW'(ptr_dist(32'(i_head), 32'(i_ld_tail), PW));

    // Walk oldest to youngest so the last deciding entry (youngest) wins.
    always_comb begin
        logic [IW-1:0] idx;
        logic          dec;
        o_hit   = 1'b0;
        o_stall = 1'b0;
        o_sel   = IW'(0);
        idx     = IW'(0);
        dec     = 1'b0;
        for (int p = 0; p < DEPTH; p++) begin
            idx     = i_head[IW-1:0] + IW'(p);
            dec     = (PW'(p) < w_older) && i_valid[idx] && (!i_filled[idx] || i_match[idx]);
            o_stall = dec ? !i_filled[idx] : o_stall;
            o_hit   = dec ? i_filled[idx]  : o_hit;
            o_sel   = dec ? idx            : o_sel;
        end
    end

endmodule

// File: rtl/store_queue_fwd.sv
// In-order store queue: allocate at decode, fill at execute, forward to loads,
// drain committed stores through a registered memory write port.
module store_queue_fwd
    import sq_pkg::*;
#(
    parameter  int DEPTH = SQ_DEPTH,
    parameter  int AW    = SQ_AW,
    parameter  int DW    = SQ_DW,
    parameter  int PCW   = SQ_PCW,
    localparam int IW    = $clog2(DEPTH),
    localparam int PW    = IW + 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           alloc_en,
    input  logic [PCW-1:0] alloc_pc,
    output logic [PW-1:0]  alloc_ptr,
    output logic           full,
    output logic           empty,
    output logic [PW-1:0]  count,
    input  logic           fill_en,
    input  logic [IW-1:0]  fill_idx,
    input  logic [AW-1:0]  fill_addr,
    input  logic [DW-1:0]  fill_data,
    input  logic           ld_en,
    input  logic [AW-1:0]  ld_addr,
    input  logic [PW-1:0]  ld_tail,
    output logic           ld_hit,
    output logic           ld_stall,
    output logic [DW-1:0]  ld_data,
    input  logic           commit_en,
    output logic           head_ready,
    input  logic           flush_en,
    input  logic [PW-1:0]  flush_tail,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_data,
    output logic [PCW-1:0] mem_pc
);

    // Same layout as sq_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic           valid;
        logic           filled;
        logic [PCW-1:0] pc;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } entry_t;

    entry_t          r_ent [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_data;
    logic [PCW-1:0]  r_mem_pc;

    logic [PW-1:0]    w_count;
    logic [PW-1:0]    w_flush_span;
    logic             w_full;
    logic             w_empty;
    logic             w_head_ready;
    logic             w_alloc;
    logic             w_commit;
    logic             w_fill;
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_filled;
    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] w_squash;
    logic             w_fwd_hit;
    logic             w_fwd_stall;
    logic [IW-1:0]    w_fwd_sel;

    assign w_count      = PW'(ptr_dist(32'(r_head), 32'(r_tail), PW));
    assign w_flush_span = PW'(ptr_dist(32'(flush_tail), 32'(r_tail), PW));
    assign w_full       = (w_count == PW'(DEPTH));
    assign w_empty      = (w_count == PW'(0));
    assign w_head_ready = r_ent[r_head[IW-1:0]].valid && r_ent[r_head[IW-1:0]].filled;
    assign w_alloc      = alloc_en && !w_full && !flush_en;
    assign w_commit     = commit_en && w_head_ready;
    assign w_fill       = fill_en && r_ent[fill_idx].valid && !w_squash[fill_idx];

    // Per-entry status vectors, address compare and flush squash window.
    always_comb begin
        w_valid  = {DEPTH{1'b0}};
        w_filled = {DEPTH{1'b0}};
        w_match  = {DEPTH{1'b0}};
        w_squash = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i]  = r_ent[i].valid;
            w_filled[i] = r_ent[i].filled;
            w_match[i]  = r_ent[i].filled && (r_ent[i].addr == ld_addr);
            w_squash[i] = flush_en &&
                (PW'(ptr_dist(32'(flush_tail[IW-1:0]), 32'(i), IW)) < w_flush_span);
        end
    end

    sq_fwd_select #(
        .DEPTH (DEPTH)
    ) u_fwd_select (
        .i_valid   (w_valid),
        .i_filled  (w_filled),
        .i_match   (w_match),
        .i_head    (r_head),
        .i_ld_tail (ld_tail),
        .o_hit     (w_fwd_hit),
        .o_stall   (w_fwd_stall),
        .o_sel     (w_fwd_sel)
    );

    // Entry storage: squash/commit clear first, then alloc and fill set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= entry_t'(0);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_squash[i] || (w_commit && (r_head[IW-1:0] == IW'(i)))) begin
                    r_ent[i].valid  <= 1'b0;
                    r_ent[i].filled <= 1'b0;
                end
            end
            if (w_alloc) begin
                r_ent[r_tail[IW-1:0]].valid  <= 1'b1;
                r_ent[r_tail[IW-1:0]].filled <= 1'b0;
                r_ent[r_tail[IW-1:0]].pc     <= alloc_pc;
            end
            if (w_fill) begin
                r_ent[fill_idx].addr   <= fill_addr;
                r_ent[fill_idx].data   <= fill_data;
                r_ent[fill_idx].filled <= 1'b1;
            end
        end
    end

    // Head/tail pointers; a flush overrides any same-cycle allocation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head <= PW'(0);
            r_tail <= PW'(0);
        end else begin
            r_tail <= flush_en ? flush_tail : (w_alloc ? r_tail + PW'(1) : r_tail);
            r_head <= w_commit ? r_head + PW'(1) : r_head;
        end
    end

    // Registered drain port, one write pulse per committed store.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= AW'(0);
            r_mem_data <= DW'(0);
            r_mem_pc   <= PCW'(0);
        end else begin
            r_mem_we <= w_commit;
            if (w_commit) begin
                r_mem_addr <= r_ent[r_head[IW-1:0]].addr;
                r_mem_data <= r_ent[r_head[IW-1:0]].data;
                r_mem_pc   <= r_ent[r_head[IW-1:0]].pc;
            end
        end
    end

    assign alloc_ptr  = r_tail;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = w_count;
    assign head_ready = w_head_ready;
    assign ld_hit     = ld_en && w_fwd_hit;
    assign ld_stall   = ld_en && w_fwd_stall;
    assign ld_data    = (ld_en && w_fwd_hit) ? r_ent[w_fwd_sel].data : DW'(0);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_pc     = r_mem_pc;

endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd with hand-computed expectations.
module tb_store_queue_fwd;

    localparam int DEPTH = 16;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int PCW   = 32;
    localparam int IW    = 4;
    localparam int PW    = 5;

    logic           clk = 1'b0;
    logic           rstn;
    logic           alloc_en;
    logic [PCW-1:0] alloc_pc;
    logic [PW-1:0]  alloc_ptr;
    logic           full;
    logic           empty;
    logic [PW-1:0]  count;
    logic           fill_en;
    logic [IW-1:0]  fill_idx;
    logic [AW-1:0]  fill_addr;
    logic [DW-1:0]  fill_data;
    logic           ld_en;
    logic [AW-1:0]  ld_addr;
    logic [PW-1:0]  ld_tail;
    logic           ld_hit;
    logic           ld_stall;
    logic [DW-1:0]  ld_data;
    logic           commit_en;
    logic           head_ready;
    logic           flush_en;
    logic [PW-1:0]  flush_tail;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_data;
    logic [PCW-1:0] mem_pc;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] flush_span;

    always #5 clk = ~clk;

    store_queue_fwd #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PCW(PCW)) dut (
        .clk(clk), .rstn(rstn),
        .alloc_en(alloc_en), .alloc_pc(alloc_pc), .alloc_ptr(alloc_ptr),
        .full(full), .empty(empty), .count(count),
        .fill_en(fill_en), .fill_idx(fill_idx), .fill_addr(fill_addr), .fill_data(fill_data),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_tail(ld_tail),
        .ld_hit(ld_hit), .ld_stall(ld_stall), .ld_data(ld_data),
        .commit_en(commit_en), .head_ready(head_ready),
        .flush_en(flush_en), .flush_tail(flush_tail),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_pc(mem_pc)
    );

    // flush_tail must lie within [head, tail]; head = tail - count.
    always @(posedge clk) begin
        if (rstn && flush_en) begin
            flush_span = alloc_ptr - flush_tail;
            assert (flush_span <= count) else $error("illegal flush_tail %0d", flush_tail);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [31:0] pc);
        alloc_en = 1'b1;
        alloc_pc = pc;
        tick();
        alloc_en = 1'b0;
    endtask

    task automatic do_fill(input int idx, input logic [7:0] a, input logic [31:0] d);
        fill_en   = 1'b1;
        fill_idx  = IW'(idx);
        fill_addr = a;
        fill_data = d;
        tick();
        fill_en = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [7:0] a, input logic [4:0] t,
                         input logic eh, input logic es, input logic [31:0] ed);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_tail = t;
        #1;
        chk({tag, "_hit"}, ld_hit, eh);
        chk({tag, "_stall"}, ld_stall, es);
        chk({tag, "_data"}, ld_data, ed);
        ld_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; alloc_en = 1'b0; alloc_pc = '0; fill_en = 1'b0; fill_idx = '0;
        fill_addr = '0; fill_data = '0; ld_en = 1'b0; ld_addr = '0; ld_tail = '0;
        commit_en = 1'b0; flush_en = 1'b0; flush_tail = '0;
        #12;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_ptr", alloc_ptr, 0);
        rstn = 1'b1;
        tick();

        // Fill the queue, then try one more allocation.
        for (int k = 0; k < 16; k++) do_alloc(32'h100 + 32'(4 * k));
        chk("fillup_count", count, 16);
        chk("fillup_full", full, 1);
        chk("fillup_ptr", alloc_ptr, 5'h10);
        do_alloc(32'h140);
        chk("over_count", count, 16);
        chk("over_ptr", alloc_ptr, 5'h10);

        // Forwarding: youngest match, stall on unknown address, miss, disabled.
        do_fill(0, 8'h20, 32'hAAAA);
        do_fill(2, 8'h20, 32'hBBBB);
        probe("fwd_young", 8'h20, 5'd3, 1'b1, 1'b0, 32'hBBBB);
        probe("fwd_stall", 8'h20, 5'd2, 1'b0, 1'b1, 32'h0);
        do_fill(1, 8'h44, 32'h5555);
        probe("fwd_after", 8'h20, 5'd2, 1'b1, 1'b0, 32'hAAAA);
        probe("fwd_miss", 8'h30, 5'd3, 1'b0, 1'b0, 32'h0);
        ld_en = 1'b0; ld_addr = 8'h20; ld_tail = 5'd3;
        #1;
        chk("ld_off_hit", ld_hit, 0);
        chk("ld_off_data", ld_data, 0);

        // Drain: three back-to-back commits, then a commit on an unfilled head.
        do_fill(0, 8'h10, 32'h1234);
        commit_en = 1'b1;
        tick();
        chk("drain0_we", mem_we, 1);
        chk("drain0_addr", mem_addr, 8'h10);
        chk("drain0_data", mem_data, 32'h1234);
        chk("drain0_pc", mem_pc, 32'h100);
        chk("drain0_count", count, 15);
        tick();
        chk("drain1_we", mem_we, 1);
        chk("drain1_addr", mem_addr, 8'h44);
        tick();
        chk("drain2_we", mem_we, 1);
        chk("drain2_data", mem_data, 32'hBBBB);
        chk("drain2_pc", mem_pc, 32'h108);
        chk("unready_head", head_ready, 0);
        tick();
        chk("unready_we", mem_we, 0);
        chk("unready_count", count, 13);
        commit_en = 1'b0;

        // Alloc + commit while full: alloc refused, commit proceeds.
        for (int k = 0; k < 3; k++) do_alloc(32'h200 + 32'(4 * k));
        chk("wrapfull", full, 1);
        do_fill(3, 8'h50, 32'h3333);
        alloc_en = 1'b1; alloc_pc = 32'h20C; commit_en = 1'b1;
        tick();
        chk("ac_full_count", count, 15);
        chk("ac_full_ptr", alloc_ptr, 5'h13);
        chk("ac_full_data", mem_data, 32'h3333);
        alloc_en = 1'b0; commit_en = 1'b0;
        do_fill(4, 8'h51, 32'h4444);
        alloc_en = 1'b1; alloc_pc = 32'h300; commit_en = 1'b1;
        tick();
        chk("ac_count", count, 15);
        chk("ac_ptr", alloc_ptr, 5'h14);
        chk("ac_pc", mem_pc, 32'h110);
        alloc_en = 1'b0; commit_en = 1'b0;

        // Advance head to 14 with tail at 20 (wrapped).
        for (int k = 5; k < 14; k++) do_fill(k, 8'(k), 32'(k));
        commit_en = 1'b1;
        repeat (9) tick();
        commit_en = 1'b0;
        chk("adv_addr", mem_addr, 8'h0D);
        chk("adv_count", count, 6);
        do_fill(14, 8'h60, 32'h6060);
        do_fill(15, 8'h61, 32'h6161);
        do_fill(0, 8'h62, 32'h6262);

        // Flush to 17 with a same-cycle alloc and a fill to a squashed index.
        flush_en = 1'b1; flush_tail = 5'd17;
        alloc_en = 1'b1; alloc_pc = 32'h400;
        fill_en = 1'b1; fill_idx = 4'd2; fill_addr = 8'h62; fill_data = 32'hDEAD;
        tick();
        flush_en = 1'b0; alloc_en = 1'b0; fill_en = 1'b0;
        chk("flush_ptr", alloc_ptr, 5'd17);
        chk("flush_count", count, 3);
        do_fill(1, 8'h62, 32'h9999);
        probe("flush_inval", 8'h62, 5'd20, 1'b1, 1'b0, 32'h6262);
        do_alloc(32'h500);
        chk("realloc_ptr", alloc_ptr, 5'd18);
        chk("realloc_count", count, 4);
        probe("realloc", 8'h62, 5'd18, 1'b0, 1'b1, 32'h0);
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("wrap_drain_addr", mem_addr, 8'h60);
        chk("wrap_drain_pc", mem_pc, 32'h138);
        chk("wrap_drain_count", count, 3);

        // Asynchronous reset in the middle of a drain pulse.
        commit_en = 1'b1;
        tick();
        chk("pre_rst_we", mem_we, 1);
        chk("pre_rst_addr", mem_addr, 8'h61);
        rstn = 1'b0;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_empty", empty, 1);
        chk("arst_count", count, 0);
        chk("arst_addr", mem_addr, 0);
        commit_en = 1'b0;
        #2;
        rstn = 1'b1;
        tick();
        chk("post_rst_empty", empty, 1);
        chk("post_rst_we", mem_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
